// File: rtl/matrix_stream_loader_pkg.sv
// matrix_loader_pkg: shared state type, default shape and width helpers for the matrix stream loader.
package matrix_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} loader_state_t;

    localparam int DEF_ELEM_W = 8;
    localparam int DEF_ROWS = 32;
    localparam int DEF_COLS = 32;
    localparam int DEF_NUM_MATS = 2;
    localparam int DIBITS_PER_ELEM = DEF_ELEM_W / 2;

    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    localparam int DIB_CNT_W = cnt_w(DIBITS_PER_ELEM);
    localparam int COL_CNT_W = cnt_w(DEF_COLS);
    localparam int ROW_CNT_W = cnt_w(DEF_ROWS);
    localparam int MAT_CNT_W = cnt_w(DEF_NUM_MATS);

endpackage

// File: rtl/dibit_deserializer.sv
// dibit_deserializer: assembles MSB-first dibits into ELEM_W-bit elements.
module dibit_deserializer
    import matrix_loader_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_W,
    localparam int DW = cnt_w(ELEM_W / 2)
) (
    input  logic              eth_refclk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [1:0]        axiid,
    input  logic              clr,
    output logic [ELEM_W-1:0] elem,
    output logic              elem_valid
);

    logic [ELEM_W-1:0] sh_q, sh_d;
    logic [DW-1:0]     cnt_q, cnt_d;

    // elem includes the current beat so a row can complete on the same edge
    always_comb begin
        elem = (sh_q << 2) | ELEM_W'(axiid);
        elem_valid = axiiv && cnt_q == DW'(ELEM_W / 2 - 1);
        sh_d = clr ? '0 : axiiv ? elem : sh_q;
        cnt_d = clr ? '0 : !axiiv ? cnt_q : elem_valid ? '0 : cnt_q + DW'(1);
    end

    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            sh_q <= '0;
            cnt_q <= '0;
        end else begin
            sh_q <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: deserialises a 2-bit payload stream into matrix rows and
// issues one row write per completed row, flagging truncated frames.
module matrix_stream_loader
    import matrix_loader_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int NUM_MATS = DEF_NUM_MATS,
    localparam int MW = cnt_w(NUM_MATS),
    localparam int AW = cnt_w(ROWS),
    localparam int CW = cnt_w(COLS),
    localparam int RW = COLS * ELEM_W
) (
    input  logic          eth_refclk,
    input  logic          rst,
    input  logic          axiiv,
    input  logic [1:0]    axiid,
    input  logic          clear,
    output logic          wr_valid,
    output logic [MW-1:0] wr_mat,
    output logic [AW-1:0] wr_addr,
    output logic [RW-1:0] wr_data,
    output logic          done,
    output logic          err
);

    loader_state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] row_q, row_d, wr_addr_q, wr_addr_d;
    logic [MW-1:0] mat_q, mat_d, wr_mat_q, wr_mat_d;
    logic [RW-1:0] buf_q, buf_d, wr_data_q, wr_data_d, merged;
    logic          wr_valid_q, wr_valid_d;
    logic          beat, deser_clr, elem_valid, row_end, mat_end, last_row;
    logic [ELEM_W-1:0] elem;

    dibit_deserializer #(.ELEM_W(ELEM_W)) u_deser (
        .eth_refclk(eth_refclk),
        .rst(rst),
        .axiiv(beat),
        .axiid(axiid),
        .clr(deser_clr),
        .elem(elem),
        .elem_valid(elem_valid)
    );

    always_comb begin
        beat = axiiv && !clear && (state_q == IDLE || state_q == LOAD);
        merged = buf_q | (RW'(elem) << (ELEM_W * (COLS - 1 - int'(col_q))));
        row_end = elem_valid && col_q == CW'(COLS - 1);
        mat_end = row_end && row_q == AW'(ROWS - 1);
        last_row = mat_end && mat_q == MW'(NUM_MATS - 1);
        state_d = state_q;
        col_d = col_q;
        row_d = row_q;
        mat_d = mat_q;
        buf_d = buf_q;
        wr_valid_d = 1'b0;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        wr_mat_d = wr_mat_q;
        if (elem_valid) begin
            buf_d = row_end ? '0 : merged;
            col_d = row_end ? '0 : col_q + CW'(1);
        end
        if (row_end) begin
            wr_valid_d = 1'b1;
            wr_data_d = merged;
            wr_addr_d = row_q;
            wr_mat_d = mat_q;
            row_d = mat_end ? '0 : row_q + AW'(1);
            mat_d = !mat_end ? mat_q : last_row ? '0 : mat_q + MW'(1);
        end
        unique case (state_q)
            IDLE: state_d = beat ? (last_row ? DONE : LOAD) : IDLE;
            LOAD: state_d = clear ? IDLE : !axiiv ? ERR : last_row ? DONE : LOAD;
            default: state_d = clear ? IDLE : state_q;
        endcase
        deser_clr = state_d != LOAD;
        // every return to IDLE restarts at matrix 0, row 0, column 0
        if (state_d == IDLE) begin
            col_d = '0;
            row_d = '0;
            mat_d = '0;
            buf_d = '0;
        end
    end

    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q <= '0;
            row_q <= '0;
            mat_q <= '0;
            buf_q <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            wr_mat_q <= '0;
        end else begin
            state_q <= state_d;
            col_q <= col_d;
            row_q <= row_d;
            mat_q <= mat_d;
            buf_q <= buf_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            wr_mat_q <= wr_mat_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_data = wr_data_q;
    assign wr_addr = wr_addr_q;
    assign wr_mat = wr_mat_q;
    assign done = state_q == DONE;
    assign err = state_q == ERR;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader: checks a 2x2x2 byte-element loader and a 32x32 6-bit loader
// against byte-level and column-index reference expectations.
module tb_matrix_stream_loader;

    logic eth_refclk = 1'b0;
    always #5 eth_refclk = ~eth_refclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        a_rst, a_axiiv, a_clear;
    logic [1:0]  a_axiid;
    logic        a_wr_valid, a_wr_mat, a_wr_addr, a_done, a_err;
    logic [15:0] a_wr_data;

    logic         b_rst, b_axiiv, b_clear;
    logic [1:0]   b_axiid;
    logic         b_wr_valid, b_wr_mat, b_done, b_err;
    logic [4:0]   b_wr_addr;
    logic [191:0] b_wr_data;

    matrix_stream_loader #(.ELEM_W(8), .ROWS(2), .COLS(2), .NUM_MATS(2)) dut_a (
        .eth_refclk(eth_refclk), .rst(a_rst), .axiiv(a_axiiv), .axiid(a_axiid), .clear(a_clear),
        .wr_valid(a_wr_valid), .wr_mat(a_wr_mat), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .done(a_done), .err(a_err)
    );

    matrix_stream_loader #(.ELEM_W(6), .ROWS(32), .COLS(32), .NUM_MATS(1)) dut_b (
        .eth_refclk(eth_refclk), .rst(b_rst), .axiiv(b_axiiv), .axiid(b_axiid), .clear(b_clear),
        .wr_valid(b_wr_valid), .wr_mat(b_wr_mat), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .done(b_done), .err(b_err)
    );

    logic [19:0]  aq[$];
    logic [198:0] bq[$];

    always @(negedge eth_refclk) begin
        if (a_wr_valid === 1'b1) aq.push_back({a_done, a_err, a_wr_mat, a_wr_addr, a_wr_data});
        if (b_wr_valid === 1'b1) bq.push_back({b_done, b_wr_mat, b_wr_addr, b_wr_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge eth_refclk);
        #1;
    endtask

    task automatic send_a(input logic [1:0] d);
        a_axiiv = 1'b1;
        a_axiid = d;
        tick();
    endtask

    task automatic idle_a(input int n);
        a_axiiv = 1'b0;
        a_axiid = 2'b00;
        repeat (n) tick();
    endtask

    task automatic clear_a();
        a_clear = 1'b1;
        a_axiiv = 1'b0;
        tick();
        a_clear = 1'b0;
        chk("rearm_done", 256'(a_done), 256'(0));
        chk("rearm_err", 256'(a_err), 256'(0));
    endtask

    // Frame word is 8 bytes, byte 0 in the MSBs, sent MSB-first as dibits.
    task automatic run_a(input logic [63:0] fr, input int n);
        aq.delete();
        for (int i = 0; i < n; i++) begin
            send_a(2'(fr >> (62 - 2 * i)));
            if (i % 8 == 7) chk("row_latency", 256'(a_wr_valid), 256'(1));
        end
        if (n < 32) chk("err_before_drop", 256'(a_err), 256'(0));
        idle_a(1);
    endtask

    // Row k of the frame is bytes 2k,2k+1; matrix k/2, row k%2; done only with the 4th row.
    task automatic model_a(input logic [63:0] fr, input int n);
        bit full;
        full = (n == 32);
        chk("done_level", 256'(a_done), 256'(full));
        chk("err_level", 256'(a_err), 256'(!full));
        chk("write_count", 256'(aq.size()), 256'(n / 8));
        for (int k = 0; k < n / 8 && k < aq.size(); k++)
            chk("write_word", 256'(aq[k]),
                256'({full && k == 3, 1'b0, 1'(k / 2), 1'(k % 2), 16'(fr >> (48 - 16 * k))}));
    endtask

    typedef struct {
        logic [63:0] frame;
        int          n_dib;
        int          exp_wr;
        logic        exp_done;
        logic        exp_err;
        logic [19:0] exp_last;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [63:0] fr;
        logic [191:0] row_word;
        int n;
        tbl[0] = '{64'h0102030405060708, 32, 4, 1'b1, 1'b0, {1'b1, 1'b0, 1'b1, 1'b1, 16'h0708}};
        tbl[1] = '{64'h0102030405060708, 10, 1, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 1'b0, 16'h0102}};
        tbl[2] = '{64'hdeadbeefcafef00d, 1, 0, 1'b0, 1'b1, 20'h0};
        tbl[3] = '{64'hdeadbeefcafef00d, 16, 2, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 1'b1, 16'hbeef}};
        tbl[4] = '{64'h00ff55aa3cc3a55a, 31, 3, 1'b0, 1'b1, {1'b0, 1'b0, 1'b1, 1'b0, 16'h3cc3}};
        tbl[5] = '{64'hffffffffffffffff, 32, 4, 1'b1, 1'b0, {1'b1, 1'b0, 1'b1, 1'b1, 16'hffff}};
        tbl[6] = '{64'h1122334455667788, 24, 3, 1'b0, 1'b1, {1'b0, 1'b0, 1'b1, 1'b0, 16'h5566}};

        a_rst = 1'b1; a_axiiv = 1'b0; a_axiid = 2'b00; a_clear = 1'b0;
        b_rst = 1'b1; b_axiiv = 1'b0; b_axiid = 2'b00; b_clear = 1'b0;
        repeat (2) tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        chk("reset_a", 256'({a_wr_valid, a_wr_mat, a_wr_addr, a_wr_data, a_done, a_err}), 256'(0));
        chk("reset_b", 256'({b_wr_valid, b_wr_mat, b_wr_addr, b_wr_data, b_done, b_err}), 256'(0));

        for (int v = 0; v < 7; v++) begin
            run_a(tbl[v].frame, tbl[v].n_dib);
            chk("tbl_count", 256'(aq.size()), 256'(tbl[v].exp_wr));
            chk("tbl_done", 256'(a_done), 256'(tbl[v].exp_done));
            chk("tbl_err", 256'(a_err), 256'(tbl[v].exp_err));
            if (tbl[v].exp_wr > 0 && aq.size() > 0) chk("tbl_last", 256'(aq[$]), 256'(tbl[v].exp_last));
            model_a(tbl[v].frame, tbl[v].n_dib);
            clear_a();
        end

        // reset in the middle of a row
        send_a(2'b01); send_a(2'b10); send_a(2'b11);
        aq.delete();
        a_rst = 1'b1;
        a_axiiv = 1'b0;
        tick();
        a_rst = 1'b0;
        chk("reset_mid_row", 256'({a_wr_valid, a_wr_mat, a_wr_addr, a_wr_data, a_done, a_err}), 256'(0));
        run_a(64'h0102030405060708, 32);
        model_a(64'h0102030405060708, 32);

        // trailing beats in DONE, then clear coinciding with a beat
        aq.delete();
        for (int i = 0; i < 8; i++) send_a(2'($urandom));
        idle_a(1);
        chk("trailing_writes", 256'(aq.size()), 256'(0));
        chk("trailing_done", 256'(a_done), 256'(1));
        a_clear = 1'b1;
        a_axiiv = 1'b1;
        a_axiid = 2'b11;
        tick();
        a_clear = 1'b0;
        chk("clear_beat_done", 256'(a_done), 256'(0));
        run_a(64'h8877665544332211, 32);
        model_a(64'h8877665544332211, 32);
        clear_a();

        // clear during LOAD aborts without error or write
        for (int i = 0; i < 12; i++) send_a(2'b10);
        aq.delete();
        a_clear = 1'b1;
        a_axiid = 2'b01;
        tick();
        a_clear = 1'b0;
        a_axiiv = 1'b0;
        chk("abort_err", 256'(a_err), 256'(0));
        chk("abort_done", 256'(a_done), 256'(0));
        tick();
        chk("abort_writes", 256'(aq.size()), 256'(0));
        run_a(64'h0f1e2d3c4b5a6978, 32);
        model_a(64'h0f1e2d3c4b5a6978, 32);
        clear_a();

        // random frames with random truncation points
        for (int it = 0; it < 24; it++) begin
            fr = {$urandom, $urandom};
            n = (it % 3 == 0) ? 32 : int'($urandom_range(1, 32));
            idle_a(int'($urandom_range(0, 3)));
            run_a(fr, n);
            model_a(fr, n);
            clear_a();
        end

        // large shape: every element equals its column index
        bq.delete();
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++)
                for (int k = 0; k < 3; k++) begin
                    b_axiiv = 1'b1;
                    b_axiid = 2'(c >> (4 - 2 * k));
                    tick();
                end
            chk("big_latency", 256'(b_wr_valid), 256'(1));
        end
        b_axiiv = 1'b0;
        tick();
        row_word = '0;
        for (int c = 0; c < 32; c++) row_word = (row_word << 6) | 192'(c);
        chk("big_count", 256'(bq.size()), 256'(32));
        chk("big_done", 256'(b_done), 256'(1));
        chk("big_err", 256'(b_err), 256'(0));
        for (int r = 0; r < 32 && r < bq.size(); r++)
            chk("big_row", 256'(bq[r]), 256'({r == 31, 1'b0, 5'(r), row_word}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Parametrised loader that deserialises a 2-bit-per-cycle Ethernet payload stream into matrix rows and emits one row-write per completed row for a downstream row BRAM. It supports any even element width, any rows × columns shape, and several matrices back-to-back in one frame (A, then B, …). It sits between the Ethernet receive path and the matrix row stores. It adds truncated-frame detection and an explicit re-arm, neither of which the first-generation loader had.

## Interface

Parameters:
- ELEM_W, 8: element width in bits; must be even and ≥ 2.
- ROWS, 32: rows per matrix.
- COLS, 32: elements per row.
- NUM_MATS, 2: matrices carried per frame, in order.

Ports:
- eth_refclk  input  1  clock; all logic runs in this domain.
- rst  input  1  reset; synchronous, active-high.
- axiiv  input  1  payload dibit valid; stays high for the whole frame.
- axiid  input  2  payload dibit, MSB-first within each element.
- clear  input  1  re-arm from DONE or ERR back to IDLE.
- wr_valid  output  1  one-cycle pulse; row write strobe.
- wr_mat  output  $clog2(NUM_MATS) (min 1)  matrix index for the write.
- wr_addr  output  $clog2(ROWS) (min 1)  row index for the write.
- wr_data  output  COLS*ELEM_W  row word; column 0 occupies the MSBs.
- done  output  1  level; all NUM_MATS matrices loaded.
- err  output  1  level; frame truncated.

## Operation

States: IDLE, LOAD, DONE, ERR.

- **IDLE**
  - The first cycle with axiiv=1 enters LOAD.
  - That cycle's dibit is captured as bits [ELEM_W-1:ELEM_W-2] of element 0.
- **LOAD**
  - Each axiiv=1 cycle shifts one dibit into the element.
  - After ELEM_W/2 dibits, the element is written into column col_cnt of the row buffer, bits [(COLS-col_cnt)*ELEM_W-1 -: ELEM_W]. col_cnt then increments.
  - When col_cnt reaches COLS-1 and its element completes, the next cycle outputs:
    - wr_valid=1,
    - wr_data = full row,
    - wr_addr = row_cnt,
    - wr_mat = mat_cnt.
  - After the row write, col_cnt resets to 0 and row_cnt increments.
  - After ROWS rows, row_cnt wraps to 0 and mat_cnt increments.
  - Completion of the last row of matrix NUM_MATS-1 enters DONE.
- **Truncation**: axiiv=0 in LOAD before completion enters ERR. The partial row is discarded and no wr_valid is issued for it.
- **DONE**
  - done=1.
  - Further axiiv beats are ignored and produce no writes.
  - clear=1 returns to IDLE.
- **ERR**
  - err=1.
  - axiiv beats are ignored.
  - clear=1 returns to IDLE.
- **clear in other states**
  - clear in IDLE has no effect.
  - clear in LOAD aborts to IDLE with no err and no write.
- **Counter reset on entering IDLE**: all counters and the row buffer clear, so the next frame restarts at matrix 0, row 0, column 0.

## Timing

- **Reset**
  - Reset values: state=IDLE, wr_valid=0, wr_mat=0, wr_addr=0, wr_data=0, done=0, err=0, all counters 0.
  - rst mid-LOAD discards all partial data and issues no write.
- **Write latency**: wr_valid rises exactly 1 cycle after the eth_refclk edge that samples the row's last dibit.
  - wr_data, wr_addr and wr_mat are valid only while wr_valid=1.
  - They hold their last value otherwise.
- **Final row**: done rises in the same cycle as the final wr_valid.
- **Entering ERR**: err rises 1 cycle after the first axiiv=0 sample in LOAD.
- **Leaving DONE/ERR**: with clear=1 at cycle t, done and err are 0 at t+1.
- **Simultaneous events**
  - clear and axiiv in the same cycle: clear wins, that beat is dropped, and the state is IDLE next cycle.
  - rst overrides clear.
- **Row throughput**: one row per COLS*ELEM_W/2 cycles, so there is no back-pressure. The downstream memory must accept a write on every wr_valid.

## Structure

- Package matrix_loader_pkg:
  - loader_state_t enum (IDLE, LOAD, DONE, ERR),
  - localparams for derived widths (DIBITS_PER_ELEM, counter widths).
- Sub-module dibit_deserializer (parameter ELEM_W):
  - inputs: axiiv, axiid, clr.
  - outputs: elem[ELEM_W-1:0] and a one-cycle elem_valid.
  - Instantiated once.
- Top level holds the FSM, column/row/matrix counters, row buffer and output registers.

## Test plan

Use ELEM_W=8, ROWS=2, COLS=2, NUM_MATS=2 unless noted.

- **Full frame**: stream bytes 0x01,0x02,0x03,0x04,0x05,0x06,0x07,0x08 as 32 dibits → four wr_valid pulses with (mat,addr,data) = (0,0,0x0102), (0,1,0x0304), (1,0,0x0506), (1,1,0x0708); done=1 with the 4th pulse.
- **Truncation**: drop axiiv after 10 dibits → one write (0,0,0x0102) only; err=1 next cycle; done=0.
- **Re-arm**: after the truncation case, pulse clear, then send a full frame → writes restart at mat=0, addr=0; err=0 from the cycle after clear.
- **Reset mid-row**: assert rst after 3 dibits → all outputs 0 next cycle; a following full frame produces the exact sequence from the full-frame case.
- **Trailing data**: extra beats in DONE produce no wr_valid. clear together with axiiv in DONE → IDLE, and that beat is not captured.
- **Large shape**: ELEM_W=6, COLS=32, ROWS=32, NUM_MATS=1, element value = column index → every row word equals the concatenation of 0..31 (6-bit each); 32 writes; done at the last write.
